// File: rtl/flash_boot_loader_pkg.sv
// ----------------------------------------------------------------------------
// flash_boot_loader_pkg
//   Shared definitions for the boot loader:
//   - Address and data widths of the flash reader and the RAM write port.
//   - The flash reader status nibble that means "idle".
//   - The sequencer state encoding.
//   - A helper that decodes the reader's idle condition.
// ----------------------------------------------------------------------------
package flash_boot_loader_pkg;

    localparam int FLASH_AW = 23;
    localparam int RAM_AW   = 18;
    localparam int DATA_W   = 16;
    // The word counter runs 0..WORDS-1, and WORDS is at most 2^18.
    localparam int CNT_W    = 19;

    localparam logic [3:0] FLASH_IDLE_NIB = 4'b0001;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_READY,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic flash_is_idle(input logic [7:0] status);
        return status[3:0] == FLASH_IDLE_NIB;
    endfunction

endpackage

// File: rtl/flash_boot_loader_timer.sv
// ----------------------------------------------------------------------------
// loader_timer
//   A saturating up-counter with a terminal-count flag. The boot loader uses
//   this counter for two jobs: the SYNC quiet window and the per-phase read
//   timeout.
//
//   Behaviour:
//   - clr has priority over en and zeroes the count.
//   - The count saturates at 2^W-1.
//   - tc is combinational. It is high in the cycle whose clock edge moves the
//     count from 2^W-2 to 2^W-1. This lets the owner act on the same edge at
//     which the count reaches its maximum, so the window is exactly
//     2^W-1 enabled cycles long.
//
//   Ports:
//   - clk : system clock
//   - rst : asynchronous, active-high reset
//   - clr : zero the count
//   - en  : count this cycle
//   - tc  : the count reaches its maximum at the next edge
// ----------------------------------------------------------------------------
module loader_timer #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_PRE = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = en && !clr && (count_reg == CNT_PRE);

endmodule

// File: rtl/flash_boot_loader.sv
// ----------------------------------------------------------------------------
// flash_boot_loader
//   Boot-time sequencer. It copies WORDS 16-bit words from flash, starting at
//   FLASH_BASE, into RAM, starting at RAM_BASE. It does one read at a time,
//   using the flash reader's toggle handshake, and holds the CPU (busy) until
//   the copy has finished.
//
//   Ports:
//   - clk             : system clock
//   - rst             : asynchronous, active-high reset
//   - start           : one-cycle pulse. Begins a copy when the loader is idle
//                       and ready.
//   - flash_addr      : word address sent to the flash reader
//   - flash_read_ctrl : toggle line. Each edge requests one read.
//   - flash_data      : read result from the flash reader
//   - flash_status    : flash reader status. The low nibble is 4'b0001 when
//                       the reader is idle.
//   - ram_addr        : RAM write address
//   - ram_data        : RAM write data
//   - ram_we          : RAM write request. Held until ram_ready.
//   - ram_ready       : RAM accepted the write in this cycle
//   - busy            : copy or start-up sync in progress (CPU hold)
//   - done            : sticky. The last copy completed. Cleared by start.
//   - error           : sticky. A read phase timed out. Only rst clears it.
// ----------------------------------------------------------------------------
module flash_boot_loader
    import flash_boot_loader_pkg::*;
#(
    parameter int unsigned          WORDS      = 512,
    parameter logic [FLASH_AW-1:0]  FLASH_BASE = 23'h0,
    parameter logic [RAM_AW-1:0]    RAM_BASE   = 18'h0,
    parameter int                   TMO_W      = 28,
    parameter int                   SYNC_W     = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [FLASH_AW-1:0] flash_addr,
    output logic                flash_read_ctrl,
    input  logic [DATA_W-1:0]   flash_data,
    input  logic [7:0]          flash_status,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_data,
    output logic                ram_we,
    input  logic                ram_ready,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    state_t              state_reg;
    logic [FLASH_AW-1:0] flash_addr_reg;
    logic                read_ctrl_reg;
    logic [RAM_AW-1:0]   ram_addr_reg;
    logic [DATA_W-1:0]   ram_data_reg;
    logic                ram_we_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                error_reg;
    logic [CNT_W-1:0]    cnt_reg;

    logic idle;
    logic sync_clr;
    logic sync_en;
    logic sync_tc;
    logic tmo_clr;
    logic tmo_en;
    logic tmo_tc;
    logic unused_status;

    assign idle          = flash_is_idle(flash_status);
    assign unused_status = ^flash_status[7:4];

    // Timer control. Each timer is held clear in every state that does not
    // use it. Inside a waiting state, the condition that ends the wait also
    // clears the timer. As a result, every timed phase starts at zero.
    // The SYNC window restarts on any cycle in which the reader is not idle.
    always_comb begin
        sync_clr = 1'b1;
        sync_en  = 1'b0;
        tmo_clr  = 1'b1;
        tmo_en   = 1'b0;
        case (state_reg)
            ST_SYNC: begin
                sync_clr = !idle;
                sync_en  = idle;
            end
            ST_WAIT_BUSY: begin
                tmo_clr = !idle;
                tmo_en  = idle;
            end
            ST_WAIT_IDLE: begin
                tmo_clr = idle;
                tmo_en  = !idle;
            end
            default: begin
            end
        endcase
    end

    loader_timer #(.W(SYNC_W)) u_sync_timer (
        .clk (clk),
        .rst (rst),
        .clr (sync_clr),
        .en  (sync_en),
        .tc  (sync_tc)
    );

    loader_timer #(.W(TMO_W)) u_tmo_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmo_clr),
        .en  (tmo_en),
        .tc  (tmo_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_SYNC;
            flash_addr_reg <= FLASH_BASE;
            read_ctrl_reg  <= 1'b0;
            ram_addr_reg   <= RAM_BASE;
            ram_data_reg   <= '0;
            ram_we_reg     <= 1'b0;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            case (state_reg)
                // After reset, the reader may still be completing a read
                // that a toggle mismatch triggered. Wait for a full quiet
                // window before accepting work.
                ST_SYNC: begin
                    if (sync_tc) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_READY;
                    end
                end

                ST_READY: begin
                    if (start) begin
                        flash_addr_reg <= FLASH_BASE;
                        ram_addr_reg   <= RAM_BASE;
                        cnt_reg        <= '0;
                        done_reg       <= 1'b0;
                        error_reg      <= 1'b0;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    read_ctrl_reg <= ~read_ctrl_reg;
                    state_reg     <= ST_WAIT_BUSY;
                end

                // Wait for the reader to show that it has taken the request.
                ST_WAIT_BUSY: begin
                    if (!idle) begin
                        state_reg <= ST_WAIT_IDLE;
                    end else if (tmo_tc) begin
                        error_reg  <= 1'b1;
                        busy_reg   <= 1'b0;
                        ram_we_reg <= 1'b0;
                        state_reg  <= ST_ERR;
                    end
                end

                // The read completes when the reader returns to idle. At
                // that point flash_data is valid.
                ST_WAIT_IDLE: begin
                    if (idle) begin
                        ram_data_reg <= flash_data;
                        ram_we_reg   <= 1'b1;
                        state_reg    <= ST_WRITE;
                    end else if (tmo_tc) begin
                        error_reg  <= 1'b1;
                        busy_reg   <= 1'b0;
                        ram_we_reg <= 1'b0;
                        state_reg  <= ST_ERR;
                    end
                end

                ST_WRITE: begin
                    if (ram_ready) begin
                        ram_we_reg <= 1'b0;
                        if (cnt_reg == LAST_IDX) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_DONE;
                        end else begin
                            // Both addresses wrap naturally at their widths.
                            flash_addr_reg <= flash_addr_reg + 1'b1;
                            ram_addr_reg   <= ram_addr_reg + 1'b1;
                            cnt_reg        <= cnt_reg + 1'b1;
                            state_reg      <= ST_ISSUE;
                        end
                    end
                end

                // A start that arrives in this cycle is dropped on purpose.
                ST_DONE: begin
                    state_reg <= ST_READY;
                end

                // Terminal state. Only rst leaves it.
                ST_ERR: begin
                    state_reg <= ST_ERR;
                end

                default: begin
                    state_reg <= ST_ERR;
                end
            endcase
        end
    end

    assign flash_addr      = flash_addr_reg;
    assign flash_read_ctrl = read_ctrl_reg;
    assign ram_addr        = ram_addr_reg;
    assign ram_data        = ram_data_reg;
    assign ram_we          = ram_we_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign error           = error_reg;

endmodule

// File: tb/tb_flash_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_flash_boot_loader
//   Directed bench for the flash boot loader. It builds two loader instances,
//   each paired with its own flash reader model and RAM model:
//   - Instance 0 copies from base 0 into base 0.
//   - Instance 1 starts near the top of both address spaces, so its addresses
//     wrap to zero.
//   The reader model answers each toggle edge with a read that lasts 12
//   cycles. It serves word data 1111/2222/3333/4444, selected by the low two
//   address bits.
// ----------------------------------------------------------------------------
module tb_flash_boot_loader;

    localparam logic [7:0] ST_IDLE_VAL = 8'hA1;
    localparam logic [7:0] ST_BUSY_VAL = 8'hA2;

    logic clk;
    logic rst;

    int n_checks;
    int n_pass;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] data_of(input logic [22:0] a);
        case (a[1:0])
            2'd0:    return 16'h1111;
            2'd1:    return 16'h2222;
            2'd2:    return 16'h3333;
            default: return 16'h4444;
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam logic [22:0] FB = (gi == 0) ? 23'h0 : 23'h7FFFFE;
        localparam logic [17:0] RB = (gi == 0) ? 18'h0 : 18'h3FFFE;

        logic        start;
        logic        ram_ready;
        logic        hang;
        logic        log_clr;
        logic [22:0] flash_addr;
        logic        flash_read_ctrl;
        logic [15:0] flash_data;
        logic [7:0]  flash_status;
        logic [17:0] ram_addr;
        logic [15:0] ram_data;
        logic        ram_we;
        logic        busy;
        logic        done;
        logic        error;

        logic        last_ctrl;
        int          busy_left;
        logic [22:0] rd_addr_lat;
        logic [15:0] ram_mem [16];
        logic [22:0] rd_log [8];
        logic [17:0] wr_log [8];
        int          rd_cnt;
        int          wr_cnt;

        flash_boot_loader #(
            .WORDS      (4),
            .FLASH_BASE (FB),
            .RAM_BASE   (RB),
            .TMO_W      (8),
            .SYNC_W     (5)
        ) dut (
            .clk             (clk),
            .rst             (rst),
            .start           (start),
            .flash_addr      (flash_addr),
            .flash_read_ctrl (flash_read_ctrl),
            .flash_data      (flash_data),
            .flash_status    (flash_status),
            .ram_addr        (ram_addr),
            .ram_data        (ram_data),
            .ram_we          (ram_we),
            .ram_ready       (ram_ready),
            .busy            (busy),
            .done            (done),
            .error           (error)
        );

        initial begin
            start        = 1'b0;
            ram_ready    = 1'b1;
            hang         = 1'b0;
            log_clr      = 1'b0;
            last_ctrl    = 1'b0;
            busy_left    = 0;
            flash_status = ST_IDLE_VAL;
            flash_data   = 16'h0;
            rd_addr_lat  = 23'h0;
            rd_cnt       = 0;
            wr_cnt       = 0;
        end

        // Reader and RAM models. The reader is not reset by rst, so after a
        // reset it can see a stray toggle edge.
        always @(posedge clk) begin
            if (busy_left > 0) begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) begin
                    flash_status <= ST_IDLE_VAL;
                    flash_data   <= data_of(rd_addr_lat);
                end
            end else if (!hang && (flash_read_ctrl != last_ctrl)) begin
                last_ctrl    <= flash_read_ctrl;
                busy_left    <= 12;
                flash_status <= ST_BUSY_VAL;
                rd_addr_lat  <= flash_addr;
                if (!log_clr) begin
                    if (rd_cnt < 8) rd_log[rd_cnt] <= flash_addr;
                    rd_cnt <= rd_cnt + 1;
                end
            end
            if (log_clr) begin
                rd_cnt <= 0;
                wr_cnt <= 0;
                for (int i = 0; i < 16; i++) ram_mem[i] <= 16'hDEAD;
            end else if (ram_we && ram_ready) begin
                ram_mem[ram_addr[3:0]] <= ram_data;
                if (wr_cnt < 8) wr_log[wr_cnt] <= ram_addr;
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs(input int idx);
        if (idx == 0) g_dut[0].log_clr = 1'b1; else g_dut[1].log_clr = 1'b1;
        @(negedge clk);
        g_dut[0].log_clr = 1'b0;
        g_dut[1].log_clr = 1'b0;
    endtask

    task automatic pulse_start(input int idx);
        if (idx == 0) g_dut[0].start = 1'b1; else g_dut[1].start = 1'b1;
        @(negedge clk);
        g_dut[0].start = 1'b0;
        g_dut[1].start = 1'b0;
    endtask

    task automatic wait_done(input int idx, input string tag);
        int   n;
        logic d;
        n = 0;
        d = (idx == 0) ? g_dut[0].done : g_dut[1].done;
        while (!d && n < 2000) begin
            @(negedge clk);
            n++;
            d = (idx == 0) ? g_dut[0].done : g_dut[1].done;
        end
        chk(tag, {31'd0, d}, 32'd1);
        $display("copy on instance %0d: done after %0d cycles", idx, n);
    endtask

    // Count the cycles spent in SYNC and the run of idle reader cycles that
    // ended it. The count starts at the negedge where rst has just dropped.
    task automatic measure_sync(output int cycles, output int quiet);
        cycles = 0;
        quiet  = 0;
        while (g_dut[0].busy && cycles < 500) begin
            if (g_dut[0].flash_status[3:0] == 4'b0001) quiet++; else quiet = 0;
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          cyc;
        int          quiet;
        int          n;
        logic        stable;
        logic        ctrl0;
        logic [17:0] a_hold;
        logic [15:0] d_hold;

        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);

        // 1: reset values, then the SYNC quiet window of 31 cycles.
        chk("rst_flash_addr0", {9'd0, g_dut[0].flash_addr}, 32'h0);
        chk("rst_flash_addr1", {9'd0, g_dut[1].flash_addr}, 32'h7FFFFE);
        chk("rst_ram_addr1",   {14'd0, g_dut[1].ram_addr}, 32'h3FFFE);
        chk("rst_outs0", {g_dut[0].flash_read_ctrl, g_dut[0].ram_we, g_dut[0].busy,
                          g_dut[0].done, g_dut[0].error, g_dut[0].ram_data, g_dut[0].ram_addr[3:0]},
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0});
        rst = 1'b0;
        measure_sync(cyc, quiet);
        $display("sync after reset: busy for %0d cycles", cyc);
        chk("sync_busy_cycles", cyc, 31);
        chk("sync_busy1_clear", {31'd0, g_dut[1].busy}, 32'd0);
        chk("ready_outs0", {g_dut[0].flash_read_ctrl, g_dut[0].ram_we, g_dut[0].done,
                            g_dut[0].error}, 4'b0000);

        // 2: plain copy of four words with ram_ready tied high.
        clear_logs(0);
        pulse_start(0);
        wait_done(0, "copy1_done");
        chk("copy1_ram0", g_dut[0].ram_mem[0], 16'h1111);
        chk("copy1_ram1", g_dut[0].ram_mem[1], 16'h2222);
        chk("copy1_ram2", g_dut[0].ram_mem[2], 16'h3333);
        chk("copy1_ram3", g_dut[0].ram_mem[3], 16'h4444);
        chk("copy1_reads", g_dut[0].rd_cnt, 4);
        chk("copy1_writes", g_dut[0].wr_cnt, 4);
        chk("copy1_rdaddr3", {9'd0, g_dut[0].rd_log[3]}, 32'h3);
        chk("copy1_ctrl", {31'd0, g_dut[0].flash_read_ctrl}, 32'd0);
        chk("copy1_flags", {g_dut[0].busy, g_dut[0].error}, 2'b00);

        // 3: RAM stalls on word 2. A start pulse during the copy is ignored.
        clear_logs(0);
        pulse_start(0);
        chk("copy2_done_clr", {g_dut[0].done, g_dut[0].busy}, 2'b01);
        n = 0;
        while (g_dut[0].rd_cnt < 3 && n < 500) begin @(negedge clk); n++; end
        chk("stall_third_read", {31'd0, g_dut[0].rd_cnt == 3}, 32'd1);
        g_dut[0].ram_ready = 1'b0;
        pulse_start(0);
        n = 0;
        while (!g_dut[0].ram_we && n < 500) begin @(negedge clk); n++; end
        a_hold = g_dut[0].ram_addr;
        d_hold = g_dut[0].ram_data;
        chk("stall_addr", {14'd0, a_hold}, 32'h2);
        chk("stall_data", {16'd0, d_hold}, 32'h3333);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!g_dut[0].ram_we || g_dut[0].ram_addr != a_hold || g_dut[0].ram_data != d_hold)
                stable = 1'b0;
            @(negedge clk);
        end
        chk("stall_stable", {31'd0, stable}, 32'd1);
        chk("stall_no_extra_read", g_dut[0].rd_cnt, 3);
        g_dut[0].ram_ready = 1'b1;
        wait_done(0, "copy2_done");
        chk("copy2_ram2", g_dut[0].ram_mem[2], 16'h3333);
        chk("copy2_ram3", g_dut[0].ram_mem[3], 16'h4444);
        chk("copy2_reads", g_dut[0].rd_cnt, 4);
        chk("copy2_writes", g_dut[0].wr_cnt, 4);

        // 5: wrapping bases on instance 1.
        clear_logs(1);
        pulse_start(1);
        wait_done(1, "wrap_done");
        chk("wrap_rd0", {9'd0, g_dut[1].rd_log[0]}, 32'h7FFFFE);
        chk("wrap_rd2", {9'd0, g_dut[1].rd_log[2]}, 32'h0);
        chk("wrap_wr1", {14'd0, g_dut[1].wr_log[1]}, 32'h3FFFF);
        chk("wrap_wr2", {14'd0, g_dut[1].wr_log[2]}, 32'h0);
        chk("wrap_ram_fe", g_dut[1].ram_mem[14], 16'h3333);
        chk("wrap_ram_ff", g_dut[1].ram_mem[15], 16'h4444);
        chk("wrap_ram_0", g_dut[1].ram_mem[0], 16'h1111);
        chk("wrap_ram_1", g_dut[1].ram_mem[1], 16'h2222);

        // 6: reset while word 2 is being read. The toggle mismatch causes a
        //    stray read, which SYNC must wait out.
        clear_logs(0);
        pulse_start(0);
        n = 0;
        while (g_dut[0].rd_cnt < 3 && n < 500) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {g_dut[0].flash_read_ctrl, g_dut[0].ram_we, g_dut[0].busy,
                            g_dut[0].done, g_dut[0].error}, 5'b00100);
        chk("midrst_flash_addr", {9'd0, g_dut[0].flash_addr}, 32'h0);
        rst = 1'b0;
        measure_sync(cyc, quiet);
        $display("sync after mid-copy reset: busy for %0d cycles, quiet run %0d", cyc, quiet);
        chk("midrst_quiet", quiet, 31);
        chk("midrst_held_long", {31'd0, cyc > 40}, 32'd1);
        chk("midrst_stray_read", g_dut[0].rd_cnt, 4);
        clear_logs(0);
        pulse_start(0);
        wait_done(0, "copy3_done");
        chk("copy3_ram0", g_dut[0].ram_mem[0], 16'h1111);
        chk("copy3_ram1", g_dut[0].ram_mem[1], 16'h2222);
        chk("copy3_ram3", g_dut[0].ram_mem[3], 16'h4444);
        chk("copy3_reads", g_dut[0].rd_cnt, 4);

        // 4: the reader ignores the toggle. Expect a timeout after 255 cycles.
        g_dut[0].hang = 1'b1;
        clear_logs(0);
        ctrl0 = g_dut[0].flash_read_ctrl;
        pulse_start(0);
        n = 0;
        while (g_dut[0].flash_read_ctrl == ctrl0 && n < 50) begin @(negedge clk); n++; end
        cyc = 0;
        while (!g_dut[0].error && cyc < 1000) begin @(negedge clk); cyc++; end
        $display("timeout: error after %0d cycles", cyc);
        chk("tmo_cycles", cyc, 255);
        chk("tmo_flags", {g_dut[0].error, g_dut[0].busy, g_dut[0].done, g_dut[0].ram_we}, 4'b1000);
        ctrl0 = g_dut[0].flash_read_ctrl;
        pulse_start(0);
        repeat (20) @(negedge clk);
        chk("err_start_ignored", {g_dut[0].error, g_dut[0].busy, g_dut[0].done}, 3'b100);
        chk("err_no_toggle", {31'd0, g_dut[0].flash_read_ctrl}, {31'd0, ctrl0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
